piso_serializer_controller: RTL and testbench
=============================================

Name: piso_serializer_controller

Overview:
- Sequencer for the N-bit parallel-in/serial-out shift register.
- Accepts parallel words on a valid/ready handshake, drives the PISO load/shift/enable controls and frames its serial output into a qualified bit stream.
- Optionally appends a parity bit; inserts programmable idle gap between frames; counts completed frames.
- Sits between a word-producing client and the PISO instance.

Parameters:
- DATA_WIDTH, 4, word width; must match PISO width, >= 2.
- GAP_CYCLES, 0, idle cycles inserted after each frame before next accept (0..255).
- COUNT_WIDTH, 8, width of frame counter.

Ports:
- Clk_In  input  1  clock, rising edge.
- Reset_In  input  1  synchronous, active-high reset.
- Data_Valid_In  input  1  client word valid.
- Data_In  input  DATA_WIDTH  client word.
- Data_Ready_Out  output  1  controller can accept a word.
- Piso_Enable_Out  output  1  to PISO Enable_In.
- Piso_Load_Out  output  1  to PISO Load_Data_Signal_In.
- Piso_Shift_Out  output  1  to PISO Shift_Data_Signal_In.
- Piso_Data_Out  output  DATA_WIDTH  to PISO Parallel_Data_In.
- Piso_Serial_In  input  1  from PISO Serial_Data_Out.
- Tx_Data_Out  output  1  framed serial bit.
- Tx_Valid_Out  output  1  Tx_Data_Out is a frame bit this cycle.
- Frame_Done_Out  output  1  one-cycle pulse on last bit of a frame.
- Busy_Out  output  1  high in any state other than IDLE.
- Frame_Count_Out  output  COUNT_WIDTH  completed frames, wraps.

Behaviour:
- States: IDLE, LOAD, SHIFT, PARITY (macro only), GAP. Registered state, Bit_Count, Gap_Count, Hold_Reg, Frame_Count.
- Reset (sync, Reset_In=1 at edge): state->IDLE, all counters and Hold_Reg->0. While Reset_In high all outputs 0, including Data_Ready_Out. Reset mid-frame abandons the frame; no Frame_Done_Out, count unchanged.
- IDLE: Data_Ready_Out=1, Piso_Enable_Out=0, Tx_Valid_Out=0. Data_Valid_In&&Data_Ready_Out at edge: Hold_Reg<=Data_In, ->LOAD. Otherwise stay.
- LOAD (1 cycle): Piso_Enable_Out=1, Piso_Load_Out=1, Piso_Data_Out=Hold_Reg. ->SHIFT, Bit_Count<=0.
- SHIFT (DATA_WIDTH cycles): Piso_Enable_Out=1, Tx_Valid_Out=1, Tx_Data_Out=Piso_Serial_In; bits emitted MSB first.
  - Piso_Shift_Out=1 only while Bit_Count<DATA_WIDTH-1. Bit_Count increments each cycle.
  - At Bit_Count==DATA_WIDTH-1: ->PARITY if macro defined, else ->GAP if GAP_CYCLES>0, else ->IDLE.
- PARITY (1 cycle): Piso_Enable_Out=1, no load/shift, Tx_Valid_Out=1, Tx_Data_Out=XOR of Hold_Reg. ->GAP or IDLE as above.
- GAP: all PISO controls 0, Tx_Valid_Out=0, Gap_Count counts 0..GAP_CYCLES-1, then ->IDLE.
- Piso_Data_Out=Hold_Reg in all states; Hold_Reg changes only on accept.
- Frame_Done_Out=1 on the final Tx_Valid_Out cycle of a frame (last SHIFT cycle, or PARITY cycle when enabled). Frame_Count increments on that same edge, wraps from all-ones to 0.
- Tx_Data_Out=0 whenever Tx_Valid_Out=0; PISO Z output never propagates.
- Piso_Load_Out and Piso_Shift_Out are never high together.
- Data_In changes outside the accept cycle have no effect.
- Frame period: DATA_WIDTH+2+GAP_CYCLES cycles (+1 with parity), counted from the IDLE accept cycle.
- All outputs are decoded combinationally from registered state and counters, gated by !Reset_In.

Optional Feature:
- Macro: PISO_SERIALIZER_CONTROLLER_PARITY_EN.
- Defined: PARITY state present. Even parity bit (XOR of Hold_Reg) follows data bits; Frame_Done_Out moves to the parity cycle.
- Undefined: PARITY state and logic absent; frame is data bits only.

Test Plan:
- Reset: hold Reset_In 2 cycles mid-SHIFT -> all outputs 0 during reset; after release Data_Ready_Out=1, Frame_Count_Out=0, no Frame_Done_Out.
- Single frame, DATA_WIDTH=4, GAP_CYCLES=0, Data_In=0xB -> Piso_Load_Out high 1 cycle; Tx_Valid_Out high 4 cycles with Tx_Data_Out 1,0,1,1; Piso_Shift_Out high first 3 of them; Frame_Done_Out on 4th; Frame_Count_Out=1.
- Back-to-back: Data_Valid_In held high with 0x6 then 0x9 -> streams 0,1,1,0 then 1,0,0,1; Data_Ready_Out high exactly one cycle between frames; 6-cycle period.
- Gap: GAP_CYCLES=3, Data_Valid_In held high -> Data_Ready_Out low for 3 cycles after each Frame_Done_Out; no Tx_Valid_Out during gap.
- Parity (macro on): Data_In=0xB -> 5 valid bits 1,0,1,1,1; Frame_Done_Out on parity bit. Data_In=0x3 -> parity bit 0.
- Wrap: COUNT_WIDTH=2, 5 frames -> Frame_Count_Out sequence 1,2,3,0,1; Data_In toggling while Busy_Out=1 does not alter the emitted bits.

Source files
------------

// File: rtl/piso_serializer_controller.sv
// -----------------------------------------------------------------------------
// piso_serializer_controller
//
// Sequencer for an N-bit parallel-in/serial-out shift register. It accepts
// parallel words on a valid/ready handshake, drives the PISO load/shift/enable
// controls and turns the PISO serial output into a qualified bit stream
// (MSB first). After each frame it inserts GAP_CYCLES idle cycles and counts
// completed frames.
//
// Optional feature (compile-time macro PISO_SERIALIZER_CONTROLLER_PARITY_EN):
//   when defined, an even-parity bit (XOR of the held word) follows the data
//   bits and Frame_Done_Out moves to that parity cycle.
//
// Parameters:
//   DATA_WIDTH  - word width, must match the PISO width (>= 2)
//   GAP_CYCLES  - idle cycles after each frame before the next accept (0..255)
//   COUNT_WIDTH - width of the wrapping completed-frame counter
//
// Ports:
//   Clk_In           in   clock, rising edge
//   Reset_In         in   synchronous active-high reset
//   Data_Valid_In    in   client word valid
//   Data_In          in   client word
//   Data_Ready_Out   out  controller can accept a word (IDLE only)
//   Piso_Enable_Out  out  to PISO Enable_In
//   Piso_Load_Out    out  to PISO Load_Data_Signal_In
//   Piso_Shift_Out   out  to PISO Shift_Data_Signal_In
//   Piso_Data_Out    out  to PISO Parallel_Data_In (held word)
//   Piso_Serial_In   in   from PISO Serial_Data_Out
//   Tx_Data_Out      out  framed serial bit (0 when not valid)
//   Tx_Valid_Out     out  Tx_Data_Out carries a frame bit this cycle
//   Frame_Done_Out   out  one-cycle pulse on the last bit of a frame
//   Busy_Out         out  high in any state other than IDLE
//   Frame_Count_Out  out  completed frames, wraps
// -----------------------------------------------------------------------------
module piso_serializer_controller #(
    parameter int DATA_WIDTH  = 4,
    parameter int GAP_CYCLES  = 0,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   Clk_In,
    input  logic                   Reset_In,
    input  logic                   Data_Valid_In,
    input  logic [DATA_WIDTH-1:0]  Data_In,
    output logic                   Data_Ready_Out,
    output logic                   Piso_Enable_Out,
    output logic                   Piso_Load_Out,
    output logic                   Piso_Shift_Out,
    output logic [DATA_WIDTH-1:0]  Piso_Data_Out,
    input  logic                   Piso_Serial_In,
    output logic                   Tx_Data_Out,
    output logic                   Tx_Valid_Out,
    output logic                   Frame_Done_Out,
    output logic                   Busy_Out,
    output logic [COUNT_WIDTH-1:0] Frame_Count_Out
);

    localparam int              BIT_W    = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
    localparam bit              HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [7:0]      GAP_LAST = HAS_GAP ? 8'(GAP_CYCLES - 1) : 8'd0;

`ifdef PISO_SERIALIZER_CONTROLLER_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_PARITY, S_GAP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;
`endif

    // Where a frame goes once its final bit has been emitted.
    localparam state_t POST_FRAME = HAS_GAP ? S_GAP : S_IDLE;

    state_t                   state, state_next;
    logic [BIT_W-1:0]         bit_count;
    logic [7:0]               gap_count;
    logic [DATA_WIDTH-1:0]    hold_reg;
    logic [COUNT_WIDTH-1:0]   frame_count;
    logic                     last_data_bit;
    logic                     frame_done;

    assign last_data_bit = (state == S_SHIFT) && (bit_count == LAST_BIT);

`ifdef PISO_SERIALIZER_CONTROLLER_PARITY_EN
    assign frame_done = (state == S_PARITY);
`else
    assign frame_done = last_data_bit;
`endif

    // NOTE: every register here is a handful of flops, so all of them (including
    // the word holding register) are cleared by reset; nothing is left undefined.
    always_ff @(posedge Clk_In) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (Reset_In) begin
            state       <= S_IDLE;
            bit_count   <= '0;
            gap_count   <= '0;
            hold_reg    <= '0;
            frame_count <= '0;
        end else begin
            state <= state_next;

            // Ready is high throughout IDLE, so valid alone completes the handshake.
            if (state == S_IDLE && Data_Valid_In)
                hold_reg <= Data_In;

            if (state == S_SHIFT)
                bit_count <= bit_count + BIT_W'(1);
            else
                bit_count <= '0;

            if (state == S_GAP)
                gap_count <= gap_count + 8'd1;
            else
                gap_count <= '0;

            if (frame_done)
                frame_count <= frame_count + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next; no latch inferred.
        state_next = state;
        case (state)
            S_IDLE:   if (Data_Valid_In) state_next = S_LOAD;
            S_LOAD:   state_next = S_SHIFT;
`ifdef PISO_SERIALIZER_CONTROLLER_PARITY_EN
            S_SHIFT:  if (last_data_bit) state_next = S_PARITY;
            S_PARITY: state_next = POST_FRAME;
`else
            S_SHIFT:  if (last_data_bit) state_next = POST_FRAME;
`endif
            S_GAP:    if (gap_count == GAP_LAST) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs decode purely from registered state; reset forces them all low.
    always_comb begin
        Data_Ready_Out  = 1'b0;
        Piso_Enable_Out = 1'b0;
        Piso_Load_Out   = 1'b0;
        Piso_Shift_Out  = 1'b0;
        Piso_Data_Out   = '0;
        Tx_Data_Out     = 1'b0;
        Tx_Valid_Out    = 1'b0;
        Frame_Done_Out  = 1'b0;
        Busy_Out        = 1'b0;
        Frame_Count_Out = '0;
        if (!Reset_In) begin
            Piso_Data_Out   = hold_reg;
            Busy_Out        = (state != S_IDLE);
            Frame_Count_Out = frame_count;
            Frame_Done_Out  = frame_done;
            case (state)
                S_IDLE: Data_Ready_Out = 1'b1;
                S_LOAD: begin
                    Piso_Enable_Out = 1'b1;
                    Piso_Load_Out   = 1'b1;
                end
                S_SHIFT: begin
                    Piso_Enable_Out = 1'b1;
                    Tx_Valid_Out    = 1'b1;
                    Tx_Data_Out     = Piso_Serial_In;
                    // The last data bit is already on the PISO output; shifting
                    // again would only push a fill bit in.
                    Piso_Shift_Out  = !last_data_bit;
                end
`ifdef PISO_SERIALIZER_CONTROLLER_PARITY_EN
                S_PARITY: begin
                    Piso_Enable_Out = 1'b1;
                    Tx_Valid_Out    = 1'b1;
                    Tx_Data_Out     = ^hold_reg;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_serializer_controller.sv
module tb_piso_serializer_controller;

    localparam int W    = 4;
    localparam int G_A  = 0;
    localparam int CW_A = 2;
    localparam int G_B  = 3;
    localparam int CW_B = 8;
`ifdef PISO_SERIALIZER_CONTROLLER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    typedef struct packed {
        logic data;
        logic last;
        logic shift;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: no gap, 2-bit counter ----------------
    logic            rst_a, valid_a, ready_a, en_a, ld_a, sh_a, ser_a, tx_a, tv_a, done_a, busy_a;
    logic [W-1:0]    data_a, pdata_a;
    logic [CW_A-1:0] cnt_a;
    logic [W-1:0]    sr_a;

    piso_serializer_controller #(.DATA_WIDTH(W), .GAP_CYCLES(G_A), .COUNT_WIDTH(CW_A)) dut_a (
        .Clk_In(clk), .Reset_In(rst_a), .Data_Valid_In(valid_a), .Data_In(data_a),
        .Data_Ready_Out(ready_a), .Piso_Enable_Out(en_a), .Piso_Load_Out(ld_a),
        .Piso_Shift_Out(sh_a), .Piso_Data_Out(pdata_a), .Piso_Serial_In(ser_a),
        .Tx_Data_Out(tx_a), .Tx_Valid_Out(tv_a), .Frame_Done_Out(done_a),
        .Busy_Out(busy_a), .Frame_Count_Out(cnt_a));

    // ---------------- DUT B: 3-cycle gap, 8-bit counter ----------------
    logic            rst_b, valid_b, ready_b, en_b, ld_b, sh_b, ser_b, tx_b, tv_b, done_b, busy_b;
    logic [W-1:0]    data_b, pdata_b;
    logic [CW_B-1:0] cnt_b;
    logic [W-1:0]    sr_b;

    piso_serializer_controller #(.DATA_WIDTH(W), .GAP_CYCLES(G_B), .COUNT_WIDTH(CW_B)) dut_b (
        .Clk_In(clk), .Reset_In(rst_b), .Data_Valid_In(valid_b), .Data_In(data_b),
        .Data_Ready_Out(ready_b), .Piso_Enable_Out(en_b), .Piso_Load_Out(ld_b),
        .Piso_Shift_Out(sh_b), .Piso_Data_Out(pdata_b), .Piso_Serial_In(ser_b),
        .Tx_Data_Out(tx_b), .Tx_Valid_Out(tv_b), .Frame_Done_Out(done_b),
        .Busy_Out(busy_b), .Frame_Count_Out(cnt_b));

    // PISO partners: load/shift when enabled, MSB on the serial pin. When
    // disabled the pin idles high so any leak into Tx_Data_Out shows up.
    always @(posedge clk) begin
        if (en_a) begin
            if (ld_a)      sr_a <= pdata_a;
            else if (sh_a) sr_a <= {sr_a[W-2:0], 1'b0};
        end
        if (en_b) begin
            if (ld_b)      sr_b <= pdata_b;
            else if (sh_b) sr_b <= {sr_b[W-2:0], 1'b0};
        end
    end
    assign ser_a = en_a ? sr_a[W-1] : 1'b1;
    assign ser_b = en_b ? sr_b[W-1] : 1'b1;

    // ---------------- scoreboard ----------------
    exp_t q_a[$], q_b[$];
    int   cq_a[$], cq_b[$];
    int   tests = 0;
    int   fails = 0;
    bit   pend[2];
    bit   gtrack[2];
    int   gn[2];
    int   cm[2];
    time  last_t[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One monitor step per DUT per negedge: pops an expected bit whenever the
    // DUT presents Tx_Valid_Out, checks the frame count one cycle after each
    // Frame_Done_Out, and measures the not-ready gap after each frame.
    task automatic mon(input int sel, input logic rst, input logic ready, input logic tv,
                       input logic td, input logic done, input logic sh, input logic ld,
                       input logic en, input logic [7:0] cnt);
        exp_t e;
        int   c;
        int   g;
        bit   empty;
        g = (sel == 0) ? G_A : G_B;
        if (rst) begin
            pend[sel]   = 1'b0;
            gtrack[sel] = 1'b0;
            return;
        end
        check($sformatf("dut%0d_load_shift_exclusive", sel), {31'b0, ld & sh}, 32'd0);
        if (!tv) check($sformatf("dut%0d_tx_data_quiet", sel), {31'b0, td}, 32'd0);
        if (pend[sel]) begin
            empty = (sel == 0) ? (cq_a.size() == 0) : (cq_b.size() == 0);
            if (empty) check($sformatf("dut%0d_count_expected", sel), 32'd0, 32'd1);
            else begin
                c = (sel == 0) ? cq_a.pop_front() : cq_b.pop_front();
                check($sformatf("dut%0d_frame_count", sel), {24'b0, cnt}, c);
            end
            pend[sel] = 1'b0;
        end
        if (gtrack[sel]) begin
            if (ready) begin
                check($sformatf("dut%0d_gap_length", sel), gn[sel], g);
                gtrack[sel] = 1'b0;
            end else begin
                check($sformatf("dut%0d_gap_no_valid", sel), {31'b0, tv}, 32'd0);
                gn[sel]++;
            end
        end
        if (tv) begin
            empty = (sel == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
            if (empty) check($sformatf("dut%0d_unexpected_bit", sel), 32'd1, 32'd0);
            else begin
                e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
                check($sformatf("dut%0d_tx_bit", sel),   {31'b0, td},   {31'b0, e.data});
                check($sformatf("dut%0d_frame_done", sel), {31'b0, done}, {31'b0, e.last});
                check($sformatf("dut%0d_shift", sel),    {31'b0, sh},   {31'b0, e.shift});
                check($sformatf("dut%0d_enable", sel),   {31'b0, en},   32'd1);
                if (done) begin
                    pend[sel]   = 1'b1;
                    gtrack[sel] = 1'b1;
                    gn[sel]     = 0;
                end
            end
        end else begin
            check($sformatf("dut%0d_done_without_bit", sel), {31'b0, done}, 32'd0);
        end
    endtask

    always @(negedge clk) begin
        mon(0, rst_a, ready_a, tv_a, tx_a, done_a, sh_a, ld_a, en_a, {6'b0, cnt_a});
        mon(1, rst_b, ready_b, tv_b, tx_b, done_b, sh_b, ld_b, en_b, cnt_b);
    end

    // ---------------- stimulus ----------------
    // Holds valid high with junk data until ready, presents the word on the
    // ready cycle, then pushes the expected frame into the scoreboard.
    task automatic send_word(input int sel, input logic [W-1:0] w, input bit b2b);
        bit   ok;
        time  t;
        exp_t e;
        int   period;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sel == 0) begin
                valid_a = 1'b1;
                if (ready_a) begin data_a = w; ok = 1'b1; end
                else data_a = W'($urandom);
            end else begin
                valid_b = 1'b1;
                if (ready_b) begin data_b = w; ok = 1'b1; end
                else data_b = W'($urandom);
            end
            if (ok) break;
        end
        if (!ok) begin
            check($sformatf("dut%0d_accept_timeout", sel), 32'd0, 32'd1);
            return;
        end
        @(posedge clk);
        t = $time;
        for (int i = W - 1; i >= 0; i--) begin
            e.data  = w[i];
            e.last  = (PAR == 0) && (i == 0);
            e.shift = (i != 0);
            if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
        end
        if (PAR != 0) begin
            e.data  = ^w;
            e.last  = 1'b1;
            e.shift = 1'b0;
            if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
        end
        cm[sel] = (sel == 0) ? ((cm[sel] + 1) % (1 << CW_A)) : ((cm[sel] + 1) % (1 << CW_B));
        if (sel == 0) cq_a.push_back(cm[sel]); else cq_b.push_back(cm[sel]);
        #1;
        period = W + 2 + PAR + ((sel == 0) ? G_A : G_B);
        if (sel == 0) begin
            check("dut0_ready_drop", {31'b0, ready_a}, 32'd0);
            check("dut0_load_pulse", {31'b0, ld_a}, 32'd1);
            check("dut0_piso_data", {28'b0, pdata_a}, {28'b0, w});
        end else begin
            check("dut1_ready_drop", {31'b0, ready_b}, 32'd0);
            check("dut1_load_pulse", {31'b0, ld_b}, 32'd1);
            check("dut1_piso_data", {28'b0, pdata_b}, {28'b0, w});
        end
        if (b2b) check($sformatf("dut%0d_frame_period", sel), 32'((t - last_t[sel]) / 10), period);
        last_t[sel] = t;
    endtask

    task automatic stop_valid(input int sel);
        @(negedge clk);
        if (sel == 0) valid_a = 1'b0; else valid_b = 1'b0;
    endtask

    // Waits for the DUT to return to IDLE with everything checked off, while
    // Data_In keeps changing underneath it.
    task automatic drain(input int sel);
        bit done_ok;
        done_ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sel == 0) data_a = W'($urandom); else data_b = W'($urandom);
            #1;
            if (sel == 0) done_ok = !busy_a && q_a.size() == 0 && cq_a.size() == 0 && !pend[0];
            else          done_ok = !busy_b && q_b.size() == 0 && cq_b.size() == 0 && !pend[1];
            if (done_ok) break;
        end
        if (!done_ok) check($sformatf("dut%0d_drain_timeout", sel), 32'd0, 32'd1);
    endtask

    task automatic check_reset_zero(input int sel);
        if (sel == 0)
            check("dut0_outputs_in_reset",
                  {15'b0, ready_a, en_a, ld_a, sh_a, pdata_a, tx_a, tv_a, done_a, busy_a, cnt_a}, 32'd0);
        else
            check("dut1_outputs_in_reset",
                  {9'b0, ready_b, en_b, ld_b, sh_b, pdata_b, tx_b, tv_b, done_b, busy_b, cnt_b}, 32'd0);
    endtask

    initial begin
        rst_a = 1'b1; valid_a = 1'b0; data_a = '0;
        rst_b = 1'b1; valid_b = 1'b0; data_b = '0;
        cm[0] = 0; cm[1] = 0;

        // Power-on reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_zero(0);
        check_reset_zero(1);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        check("dut0_ready_after_reset", {31'b0, ready_a}, 32'd1);
        check("dut0_busy_after_reset", {31'b0, busy_a}, 32'd0);
        check("dut1_ready_after_reset", {31'b0, ready_b}, 32'd1);

        // Single frame 0xB: bits 1,0,1,1 (parity 1 when enabled).
        send_word(0, 4'hB, 1'b0);
        stop_valid(0);
        drain(0);
        check("dut0_count_after_single", {30'b0, cnt_a}, 32'd1);

        // Reset held for two edges in the middle of SHIFT abandons the frame.
        send_word(0, 4'h5, 1'b0);
        stop_valid(0);
        @(posedge clk);
        #1;
        rst_a = 1'b1;
        q_a.delete();
        cq_a.delete();
        cm[0] = 0;
        @(negedge clk);
        check_reset_zero(0);
        @(posedge clk);
        @(negedge clk);
        check_reset_zero(0);
        @(posedge clk);
        #1;
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("dut0_ready_post_reset", {31'b0, ready_a}, 32'd1);
            check("dut0_count_post_reset", {30'b0, cnt_a}, 32'd0);
            check("dut0_no_done_post_reset", {31'b0, done_a}, 32'd0);
        end

        // Back-to-back burst: 0x6 -> 0,1,1,0 ; 0x9 -> 1,0,0,1 ; then three more
        // frames so the 2-bit counter runs 1,2,3,0,1.
        send_word(0, 4'h6, 1'b0);
        send_word(0, 4'h9, 1'b1);
        send_word(0, 4'h3, 1'b1);
        send_word(0, 4'hC, 1'b1);
        send_word(0, 4'h0, 1'b1);
        stop_valid(0);
        drain(0);
        check("dut0_count_after_wrap", {30'b0, cnt_a}, 32'd1);

        // Gap DUT: 0xB then 0x3 (parity bit 0) with valid held high.
        send_word(1, 4'hB, 1'b0);
        send_word(1, 4'h3, 1'b1);
        stop_valid(1);
        drain(1);
        check("dut1_count_after_gap", {24'b0, cnt_b}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
